// File: rtl/dual_port_dmem_responder.sv
// Two-core shared data memory with test-and-set lock bank and round-robin arbitration.
// Optional per-port access counters are enabled by defining DMEM_ACCESS_COUNT_EN.
module dual_port_dmem_responder #(
    parameter int          WORDS     = 32,
    parameter int          LOCKS     = 8,
    parameter logic [31:0] LOCK_BASE = 32'h0000_0080
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           c0_addr_i,
    input  logic [31:0]           c0_data_i,
    input  logic                  c0_MemRead_i,
    input  logic                  c0_MemWrite_i,
    output logic [31:0]           c0_data_o,
    input  logic [31:0]           c1_addr_i,
    input  logic [31:0]           c1_data_i,
    input  logic                  c1_MemRead_i,
    input  logic                  c1_MemWrite_i,
    output logic [31:0]           c1_data_o,
    output logic [32*WORDS-1:0]   memory_o,
    output logic                  prio_o,
    output logic                  err_o
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]           c0_rd_cnt_o,
    output logic [15:0]           c0_wr_cnt_o,
    output logic [15:0]           c1_rd_cnt_o,
    output logic [15:0]           c1_wr_cnt_o
`endif
);

    localparam int          AW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int          LW     = (LOCKS > 1) ? $clog2(LOCKS) : 1;
    localparam logic [31:0] AEND   = 32'(4 * WORDS);
    localparam logic [31:0] LEND   = LOCK_BASE + 32'(4 * LOCKS);
    localparam logic [LW-1:0] LB_IDX = LOCK_BASE[LW+1:2];

    logic [31:0]      mem_q [WORDS];
    logic [31:0]      mem_d [WORDS];
    logic [LOCKS-1:0] lock_q, lock_d;
    logic             prio_q, prio_d;
    logic             err_q, err_d;

    logic [31:0]   addr [2];
    logic [31:0]   wdat [2];
    logic [31:0]   rdat [2];
    logic          rreq [2];
    logic          wreq [2];
    logic          bad  [2];
    logic          rd   [2];
    logic          wr   [2];
    logic          isl  [2];
    logic [AW-1:0] aidx [2];
    logic [LW-1:0] lidx [2];
    logic          lrd_c;
    logic          same_w;
    logic          sel;

    assign addr[0] = c0_addr_i;
    assign addr[1] = c1_addr_i;
    assign wdat[0] = c0_data_i;
    assign wdat[1] = c1_data_i;
    assign rreq[0] = c0_MemRead_i;
    assign rreq[1] = c1_MemRead_i;
    assign wreq[0] = c0_MemWrite_i;
    assign wreq[1] = c1_MemWrite_i;

    // A port raising both strobes is treated as a pure write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            isl[p]  = (addr[p] >= LOCK_BASE) && (addr[p] < LEND);
            bad[p]  = (rreq[p] || wreq[p]) &&
                      ((addr[p][1:0] != 2'b00) ||
                       !((addr[p] < AEND) || isl[p]));
            wr[p]   = wreq[p] && !bad[p];
            rd[p]   = rreq[p] && !wreq[p] && !bad[p];
            aidx[p] = addr[p][AW+1:2];
            lidx[p] = addr[p][LW+1:2] - LB_IDX;
        end
    end

    always_comb begin
        lrd_c = rd[0] && rd[1] && isl[0] && isl[1] &&
                (lidx[0] == lidx[1]) && !lock_q[lidx[0]];
        for (int p = 0; p < 2; p++) begin
            rdat[p] = '0;
            if (rd[p]) begin
                if (isl[p])
                    rdat[p] = {31'b0, lock_q[lidx[p]] |
                               (lrd_c && (prio_q != (p == 1)))};
                else
                    rdat[p] = mem_q[aidx[p]];
            end
        end
    end

    assign c0_data_o = rdat[0];
    assign c1_data_o = rdat[1];

    // Test-and-set first, then writes: loser before winner so the winner lands last.
    always_comb begin
        mem_d  = mem_q;
        lock_d = lock_q;
        prio_d = prio_q;
        err_d  = err_q | bad[0] | bad[1];
        sel    = 1'b0;
        for (int p = 0; p < 2; p++)
            if (rd[p] && isl[p])
                lock_d[lidx[p]] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sel = (k == 0) ? !prio_q : prio_q;
            if (wr[sel]) begin
                if (isl[sel])
                    lock_d[lidx[sel]] = wdat[sel][0];
                else
                    mem_d[aidx[sel]] = wdat[sel];
            end
        end
        same_w = wr[0] && wr[1] && (isl[0] == isl[1]) &&
                 (isl[0] ? (lidx[0] == lidx[1]) : (aidx[0] == aidx[1]));
        if (lrd_c || same_w)
            prio_d = !prio_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q  <= '{default: '0};
            lock_q <= '0;
            prio_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            lock_q <= lock_d;
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

    for (genvar i = 0; i < WORDS; i++) begin : g_img
        assign memory_o[32*i +: 32] = mem_q[i];
    end

    assign prio_o = prio_q;
    assign err_o  = err_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rdc_q [2];
    logic [15:0] wrc_q [2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdc_q <= '{default: '0};
            wrc_q <= '{default: '0};
        end else begin
            for (int p = 0; p < 2; p++) begin
                rdc_q[p] <= rdc_q[p] + 16'(rd[p]);
                wrc_q[p] <= wrc_q[p] + 16'(wr[p]);
            end
        end
    end

    assign c0_rd_cnt_o = rdc_q[0];
    assign c0_wr_cnt_o = wrc_q[0];
    assign c1_rd_cnt_o = rdc_q[1];
    assign c1_wr_cnt_o = wrc_q[1];
`endif

endmodule

// File: tb/tb_dual_port_dmem_responder.sv
// Scoreboard bench for dual_port_dmem_responder: stimulus queues expectations,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_dual_port_dmem_responder;

    localparam int WORDS = 32;

    localparam int S_C0   = 0;
    localparam int S_C1   = 1;
    localparam int S_WORD = 2;
    localparam int S_PRIO = 3;
    localparam int S_ERR  = 4;
    localparam int S_C0R  = 5;
    localparam int S_C0W  = 6;
    localparam int S_C1R  = 7;
    localparam int S_C1W  = 8;

    typedef struct {
        int          tag;
        int          sel;
        int          idx;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic [31:0]         c0_addr = '0, c0_wdat = '0, c1_addr = '0, c1_wdat = '0;
    logic                c0_rd = 1'b0, c0_wr = 1'b0, c1_rd = 1'b0, c1_wr = 1'b0;
    logic [31:0]         c0_data_o, c1_data_o;
    logic [32*WORDS-1:0] memory_o;
    logic                prio_o, err_o;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0]         c0_rd_cnt_o, c0_wr_cnt_o, c1_rd_cnt_o, c1_wr_cnt_o;
`endif

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];

    dual_port_dmem_responder #(.WORDS(WORDS)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .c0_addr_i     (c0_addr),
        .c0_data_i     (c0_wdat),
        .c0_MemRead_i  (c0_rd),
        .c0_MemWrite_i (c0_wr),
        .c0_data_o     (c0_data_o),
        .c1_addr_i     (c1_addr),
        .c1_data_i     (c1_wdat),
        .c1_MemRead_i  (c1_rd),
        .c1_MemWrite_i (c1_wr),
        .c1_data_o     (c1_data_o),
        .memory_o      (memory_o),
        .prio_o        (prio_o),
        .err_o         (err_o)
`ifdef DMEM_ACCESS_COUNT_EN
        ,
        .c0_rd_cnt_o   (c0_rd_cnt_o),
        .c0_wr_cnt_o   (c0_wr_cnt_o),
        .c1_rd_cnt_o   (c1_rd_cnt_o),
        .c1_wr_cnt_o   (c1_wr_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sel, int idx);
        case (sel)
            S_C0:   return c0_data_o;
            S_C1:   return c1_data_o;
            S_WORD: return memory_o[32*idx +: 32];
            S_PRIO: return {31'b0, prio_o};
            S_ERR:  return {31'b0, err_o};
`ifdef DMEM_ACCESS_COUNT_EN
            S_C0R:  return {16'b0, c0_rd_cnt_o};
            S_C0W:  return {16'b0, c0_wr_cnt_o};
            S_C1R:  return {16'b0, c1_rd_cnt_o};
            S_C1W:  return {16'b0, c1_wr_cnt_o};
`endif
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        int i;
        logic [31:0] a;
        i = 0;
        while (i < q.size()) begin
            if (q[i].tag == cyc) begin
                a = actual(q[i].sel, q[i].idx);
                n_total++;
                if (a === q[i].val)
                    n_pass++;
                else
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             q[i].nm, a, q[i].val, cyc);
                q.delete(i);
            end else if (q[i].tag < cyc) begin
                n_total++;
                $display("FAIL %s: never sampled (due cycle %0d)",
                         q[i].nm, q[i].tag);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic vec(input bit rst,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input bit r0, input bit w0,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input bit r1, input bit w1);
        @(posedge clk);
        #1;
        rst_i   = rst;
        c0_addr = a0;
        c0_wdat = d0;
        c0_rd   = r0;
        c0_wr   = w0;
        c1_addr = a1;
        c1_wdat = d1;
        c1_rd   = r1;
        c1_wr   = w1;
    endtask

    task automatic idle();
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_v(input int dly, input int sel, input int idx,
                            input logic [31:0] val, input string nm);
        exp_t e;
        e.tag = cyc + dly;
        e.sel = sel;
        e.idx = idx;
        e.val = val;
        e.nm  = nm;
        q.push_back(e);
    endtask

    initial begin
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        expect_v(0, S_PRIO, 0, 0, "reset_prio");
        expect_v(0, S_ERR, 0, 0, "reset_err");
        expect_v(0, S_C0, 0, 0, "reset_c0_data");
        expect_v(0, S_C1, 0, 0, "reset_c1_data");
        expect_v(0, S_WORD, 1, 0, "reset_word1");

        vec(0, 32'h04, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0);
        expect_v(1, S_WORD, 1, 32'hDEADBEEF, "wr_word1");
        vec(0, 0, 0, 0, 0, 32'h04, 0, 1, 0);
        expect_v(0, S_C1, 0, 32'hDEADBEEF, "c1_rd_word1");

        vec(0, 32'h10, 32'h11, 0, 1, 32'h10, 32'h22, 0, 1);
        expect_v(1, S_WORD, 4, 32'h11, "wconf1_word4");
        expect_v(1, S_PRIO, 0, 1, "wconf1_prio");
        vec(0, 32'h10, 32'h33, 0, 1, 32'h10, 32'h44, 0, 1);
        expect_v(1, S_WORD, 4, 32'h44, "wconf2_word4");
        expect_v(1, S_PRIO, 0, 0, "wconf2_prio");

        vec(0, 32'h80, 0, 1, 0, 32'h80, 0, 1, 0);
        expect_v(0, S_C0, 0, 0, "tas_c0_wins");
        expect_v(0, S_C1, 0, 1, "tas_c1_loses");
        expect_v(1, S_PRIO, 0, 1, "tas_prio");
        vec(0, 32'h80, 0, 0, 1, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 32'h80, 0, 1, 0);
        expect_v(0, S_C1, 0, 0, "lock_released");

        vec(0, 32'h14, 32'hA, 0, 1, 32'h18, 32'hB, 0, 1);
        expect_v(1, S_WORD, 5, 32'hA, "dual_wr_word5");
        expect_v(1, S_WORD, 6, 32'hB, "dual_wr_word6");
        expect_v(1, S_PRIO, 0, 1, "dual_wr_prio_kept");

        vec(0, 32'h08, 32'h55, 1, 1, 0, 0, 0, 0);
        expect_v(0, S_C0, 0, 0, "rdwr_same_port_data");
        expect_v(1, S_WORD, 2, 32'h55, "rdwr_same_port_word2");
        vec(0, 32'h08, 32'h66, 0, 1, 32'h08, 0, 1, 0);
        expect_v(0, S_C1, 0, 32'h55, "no_bypass_old");
        expect_v(1, S_WORD, 2, 32'h66, "no_bypass_word2");

        vec(0, 32'h80, 0, 1, 0, 32'h80, 32'h0, 0, 1);
        expect_v(0, S_C0, 0, 1, "mixed_lock_reader");
        expect_v(1, S_PRIO, 0, 1, "mixed_lock_prio");
        vec(0, 32'h80, 0, 1, 0, 0, 0, 0, 0);
        expect_v(0, S_C0, 0, 0, "mixed_lock_end0");

        vec(0, 32'h84, 32'h0, 0, 1, 32'h84, 32'h1, 0, 1);
        expect_v(1, S_PRIO, 0, 0, "lock_wconf_prio");
        vec(0, 32'h88, 0, 1, 0, 32'h84, 0, 1, 0);
        expect_v(0, S_C1, 0, 1, "lock_wconf_c1_won");
        expect_v(0, S_C0, 0, 0, "lock2_free");

        vec(0, 32'h7C, 32'h77, 0, 1, 0, 0, 0, 0);
        vec(0, 32'h7C, 0, 1, 0, 0, 0, 0, 0);
        expect_v(0, S_C0, 0, 32'h77, "top_word31");
        expect_v(0, S_ERR, 0, 0, "err_clear");

        vec(0, 0, 0, 0, 0, 32'h200, 0, 1, 0);
        expect_v(0, S_C1, 0, 0, "oor_read_zero");
        expect_v(1, S_ERR, 0, 1, "oor_err_set");
        vec(0, 32'h06, 32'hFF, 0, 1, 0, 0, 0, 0);
        expect_v(1, S_WORD, 1, 32'hDEADBEEF, "misal_wr_ignored");
        vec(0, 32'h05, 0, 1, 0, 32'hA0, 0, 1, 0);
        expect_v(0, S_C0, 0, 0, "misal_read_zero");
        expect_v(0, S_C1, 0, 0, "past_locks_zero");
        idle();
        idle();
        expect_v(0, S_ERR, 0, 1, "err_sticky");

        vec(1, 32'h00, 32'h99, 0, 1, 0, 0, 0, 0);
        idle();
        expect_v(0, S_WORD, 0, 0, "rst_drops_write");
        expect_v(0, S_WORD, 4, 0, "rst_word4");
        expect_v(0, S_WORD, 2, 0, "rst_word2");
        expect_v(0, S_ERR, 0, 0, "rst_err");
        expect_v(0, S_PRIO, 0, 0, "rst_prio");
        vec(0, 0, 0, 0, 0, 32'h84, 0, 1, 0);
        expect_v(0, S_C1, 0, 0, "rst_lock1_free");

`ifdef DMEM_ACCESS_COUNT_EN
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        expect_v(0, S_C0R, 0, 0, "cnt_reset");
        vec(0, 32'h00, 0, 1, 0, 0, 0, 0, 0);
        vec(0, 32'h04, 0, 1, 0, 0, 0, 0, 0);
        vec(0, 32'h80, 0, 1, 0, 0, 0, 0, 0);
        vec(0, 32'h0C, 32'h1, 0, 1, 0, 0, 0, 0);
        vec(0, 32'h84, 32'h1, 0, 1, 0, 0, 0, 0);
        vec(0, 32'h200, 0, 1, 0, 0, 0, 0, 0);
        idle();
        expect_v(0, S_C0R, 0, 3, "cnt_c0_rd");
        expect_v(0, S_C0W, 0, 2, "cnt_c0_wr");
        expect_v(0, S_C1R, 0, 0, "cnt_c1_rd");
        expect_v(0, S_C1W, 0, 0, "cnt_c1_wr");
`endif

        idle();
        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(posedge clk);
        while (q.size() > 0) begin
            n_total++;
            $display("FAIL %s: still pending at end", q[0].nm);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
